// File: rtl/sync_filter.sv
// sync_filter: multi-channel async input synchroniser with per-channel debounce filter and edge pulses
module sync_filter #(
  parameter int               WIDTH    = 1,
  parameter int               STAGES   = 2,
  parameter int               FILT_LEN = 4,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             CLKip,
  input  logic             RSTi,
  input  logic [WIDTH-1:0] SIGi,
  output logic [WIDTH-1:0] SIGo,
  output logic [WIDTH-1:0] RISEo,
  output logic [WIDTH-1:0] FALLo
);
  localparam int CW = FILT_LEN > 1 ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter: STAGES must be >= 2");
  end
  if (FILT_LEN < 1) begin : g_bad_filt
    $error("sync_filter: FILT_LEN must be >= 1");
  end

  logic [WIDTH-1:0] stg_q [STAGES];

  // plain flop chain per channel, nothing between stages
  always_ff @(posedge CLKip) begin
    if (RSTi) begin
      for (int k = 0; k < STAGES; k++) stg_q[k] <= RST_VAL;
    end else begin
      stg_q[0] <= SIGi;
      for (int k = 1; k < STAGES; k++) stg_q[k] <= stg_q[k-1];
    end
  end

  for (genvar c = 0; c < WIDTH; c++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sig_q, sig_d, rise_q, rise_d, fall_q, fall_d, s, hit;
    assign s = stg_q[STAGES-1][c];
    // output follows only after FILT_LEN consecutive differing samples; any match clears the count
    always_comb begin
      hit    = (s != sig_q) && (cnt_q == LAST);
      cnt_d  = (s == sig_q || hit) ? '0 : cnt_q + CW'(1);
      sig_d  = hit ? s : sig_q;
      rise_d = hit && s;
      fall_d = hit && !s;
    end
    // filter state and single-cycle event pulses
    always_ff @(posedge CLKip) begin
      if (RSTi) begin
        cnt_q  <= '0;
        sig_q  <= RST_VAL[c];
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        sig_q  <= sig_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end
    assign SIGo[c]  = sig_q;
    assign RISEo[c] = rise_q;
    assign FALLo[c] = fall_q;
  end
endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: directed self-checking bench for sync_filter across several parameter sets
module tb_sync_filter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1, rst3 = 1'b1;
  logic [0:0] sig0 = '0, so0, ri0, fa0;
  logic [0:0] sig1 = '0, so1, ri1, fa1;
  logic [3:0] sig2 = '0, so2, ri2, fa2;
  logic [0:0] sig3 = '0, so3, ri3, fa3;

  sync_filter u0 (.CLKip(clk), .RSTi(rst0), .SIGi(sig0), .SIGo(so0), .RISEo(ri0), .FALLo(fa0));
  sync_filter #(.RST_VAL(1'b1)) u1 (.CLKip(clk), .RSTi(rst1), .SIGi(sig1), .SIGo(so1), .RISEo(ri1), .FALLo(fa1));
  sync_filter #(.WIDTH(4)) u2 (.CLKip(clk), .RSTi(rst2), .SIGi(sig2), .SIGo(so2), .RISEo(ri2), .FALLo(fa2));
  sync_filter #(.STAGES(3), .FILT_LEN(1)) u3 (.CLKip(clk), .RSTi(rst3), .SIGi(sig3), .SIGo(so3), .RISEo(ri3), .FALLo(fa3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int e, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  initial begin
    sig0 = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk("rst_so", e, 4'(so0), 4'h0);
      chk("rst_rise", e, 4'(ri0), 4'h0);
      chk("rst_fall", e, 4'(fa0), 4'h0);
      chk("rstval1_so", e, 4'(so1), 4'h1);
    end
    rst0 = 1'b0;
    rst2 = 1'b0;
    rst3 = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("rise_so", e, 4'(so0), 4'(e >= 6));
      chk("rise_pulse", e, 4'(ri0), 4'(e == 6));
      chk("rise_nofall", e, 4'(fa0), 4'h0);
    end
    sig0 = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("fall_so", e, 4'(so0), 4'(e < 6));
      chk("fall_pulse", e, 4'(fa0), 4'(e == 6));
      chk("fall_norise", e, 4'(ri0), 4'h0);
    end
    for (int e = 1; e <= 10; e++) begin
      sig0 = 1'(e <= 3);
      step();
      chk("glitch3_so", e, 4'(so0), 4'h0);
      chk("glitch3_rise", e, 4'(ri0), 4'h0);
    end
    for (int e = 1; e <= 14; e++) begin
      sig0 = 1'(e <= 4);
      step();
      chk("glitch4_so", e, 4'(so0), 4'(e >= 6 && e < 10));
      chk("glitch4_rise", e, 4'(ri0), 4'(e == 6));
      chk("glitch4_fall", e, 4'(fa0), 4'(e == 10));
    end
    sig0 = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      rst0 = (e == 4);
      step();
      chk("rstmid_so", e, 4'(so0), 4'(e >= 10));
      chk("rstmid_rise", e, 4'(ri0), 4'(e == 10));
    end
    for (int e = 1; e <= 10; e++) begin
      sig2 = (e >= 3) ? 4'b0111 : 4'b0101;
      step();
      chk("ch_so", e, so2, (e >= 8) ? 4'b0111 : (e >= 6) ? 4'b0101 : 4'b0000);
      chk("ch_rise", e, ri2, (e == 8) ? 4'b0010 : (e == 6) ? 4'b0101 : 4'b0000);
      chk("ch_fall", e, fa2, 4'b0000);
    end
    sig3 = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("corner_so", e, 4'(so3), 4'(e >= 4));
      chk("corner_rise", e, 4'(ri3), 4'(e == 4));
    end
    sig3 = 1'b0;
    for (int e = 1; e <= 5; e++) step();
    chk("corner_low", 5, 4'(so3), 4'h0);
    for (int e = 1; e <= 6; e++) begin
      sig3 = 1'(e == 1);
      step();
      chk("pulse_so", e, 4'(so3), 4'(e == 4));
      chk("pulse_rise", e, 4'(ri3), 4'(e == 4));
      chk("pulse_fall", e, 4'(fa3), 4'(e == 5));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
